// File: rtl/depacketizer_ta.sv
// depacketizer_ta: reassembles PACKETIZER_WIDTH NoC flits into one payload
// {tag, data}, strips the flit/packet headers and presents the result on a
// ready/valid output together with the head flit's dst and vc fields.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a head flit; stray body flits flagged on err_out
//   BODY  | head latched, collecting body flits into payload slice cnt
//   HOLD  | packet complete, valid_out high until ready_in accepts it
module depacketizer_ta #(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_IN         = 12,
   parameter int WIDTH_OUT        = 36,
   parameter int PACKETIZER_WIDTH = 1,
   parameter int TAG_WIDTH        = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [WIDTH_OUT-1:0]        data_in,
   input  logic                        valid_in,
   output logic                        ready_out,
   output logic [WIDTH_IN-1:0]         data_out,
   output logic [TAG_WIDTH-1:0]        tag_out,
   output logic [ADDRESS_WIDTH-1:0]    dst_out,
   output logic [VC_ADDRESS_WIDTH-1:0] vc_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        err_out
);

   // head payload bits, body payload bits, total payload and buffer widths
   localparam int HP    = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
   localparam int BP    = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH;
   localparam int PAY_W = WIDTH_IN + TAG_WIDTH;
   localparam int BUF_W = HP + (PACKETIZER_WIDTH - 1) * BP;
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKETIZER_WIDTH - 1);
   localparam bit SINGLE = (PACKETIZER_WIDTH == 1);

   // a packet too small for {tag, data} or an unsupported flit count is a
   // build error, caught at elaboration
   if (BUF_W < PAY_W || PACKETIZER_WIDTH < 1 || PACKETIZER_WIDTH > 4) begin : g_capacity_check
      $fatal(1, "depacketizer_ta: packet capacity %0d below payload %0d or bad flit count",
             BUF_W, PAY_W);
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BODY = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q;
   logic [BUF_W-1:0]            buf_q;
   logic [ADDRESS_WIDTH-1:0]    dst_q;
   logic [VC_ADDRESS_WIDTH-1:0] vc_q;
   logic                        err_q, err_d;
   logic                        load_head, load_body;

   logic                        flit_v, flit_h, flit_t, accept;
   logic [VC_ADDRESS_WIDTH-1:0] flit_vc;
   logic [ADDRESS_WIDTH-1:0]    flit_dst;
   logic [HP-1:0]               head_pay;
   logic [BP-1:0]               body_pay;
   logic                        unused_bits;

   assign flit_v   = data_in[WIDTH_OUT-1];
   assign flit_h   = data_in[WIDTH_OUT-2];
   assign flit_t   = data_in[WIDTH_OUT-3];
   assign flit_vc  = data_in[WIDTH_OUT-4 -: VC_ADDRESS_WIDTH];
   assign flit_dst = data_in[WIDTH_OUT-4-VC_ADDRESS_WIDTH -: ADDRESS_WIDTH];
   assign head_pay = data_in[HP-1:0];
   assign body_pay = data_in[BP-1:0];

   assign ready_out = (state_q != HOLD);
   assign valid_out = (state_q == HOLD);
   assign accept    = valid_in && ready_out;

   assign data_out = buf_q[WIDTH_IN-1:0];
   assign tag_out  = buf_q[WIDTH_IN +: TAG_WIDTH];
   assign dst_out  = dst_q;
   assign vc_out   = vc_q;
   assign err_out  = err_q;

   // payload capacity above {tag, data} is carried but never presented
   assign unused_bits = ^buf_q;

   // state and registered error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // next-state decode; flits with V=0 fall through with no effect
   always_comb begin
      state_d   = state_q;
      err_d     = 1'b0;
      load_head = 1'b0;
      load_body = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && flit_v) begin
               if (flit_h) begin
                  load_head = 1'b1;
                  state_d   = (SINGLE || flit_t) ? HOLD : BODY;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         BODY: begin
            if (accept && flit_v) begin
               if (flit_h) begin
                  // new head aborts the partial packet and restarts with it
                  err_d     = 1'b1;
                  load_head = 1'b1;
                  state_d   = (SINGLE || flit_t) ? HOLD : BODY;
               end else begin
                  load_body = 1'b1;
                  if (cnt_q == LAST_CNT) begin
                     state_d = HOLD;
                     err_d   = !flit_t;
                  end else if (flit_t) begin
                     state_d = HOLD;
                     err_d   = 1'b1;
                  end
               end
            end
         end
         HOLD: begin
            if (ready_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // payload buffer, slice counter and head fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
         cnt_q <= '0;
         dst_q <= '0;
         vc_q  <= '0;
      end else if (load_head) begin
         // zero-extending clears every slice not yet written for this packet
         buf_q <= BUF_W'(head_pay);
         cnt_q <= CNT_W'(1);
         dst_q <= flit_dst;
         vc_q  <= flit_vc;
      end else if (load_body) begin
         for (int k = 1; k < PACKETIZER_WIDTH; k++) begin
            if (cnt_q == CNT_W'(k)) buf_q[HP + (k-1)*BP +: BP] <= body_pay;
         end
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_depacketizer_ta.sv
// Bench for depacketizer_ta: one single-flit instance (defaults) and one
// two-flit instance with a 40-bit data word, driven with directed and
// random packets and checked against fields the bench chose itself.
module tb_depacketizer_ta;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;

   // cycle counter used for throughput measurement
   always @(posedge clk) cyc <= cyc + 1;

   // single-flit instance
   logic [35:0] d1_in;
   logic        v1_in, r1_out, vo1, ri1, err1;
   logic [11:0] d1_out;
   logic [7:0]  t1_out;
   logic [3:0]  dst1;
   logic [0:0]  vc1;

   // two-flit instance
   logic [35:0] d2_in;
   logic        v2_in, r2_out, vo2, ri2, err2;
   logic [39:0] d2_out;
   logic [7:0]  t2_out;
   logic [3:0]  dst2;
   logic [0:0]  vc2;

   int n_cmp  = 0;
   int n_fail = 0;

   depacketizer_ta u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(d1_in), .valid_in(v1_in),
      .ready_out(r1_out), .data_out(d1_out), .tag_out(t1_out),
      .dst_out(dst1), .vc_out(vc1), .valid_out(vo1), .ready_in(ri1),
      .err_out(err1)
   );

   depacketizer_ta #(.WIDTH_IN(40), .PACKETIZER_WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .data_in(d2_in), .valid_in(v2_in),
      .ready_out(r2_out), .data_out(d2_out), .tag_out(t2_out),
      .dst_out(dst2), .vc_out(vc2), .valid_out(vo2), .ready_in(ri2),
      .err_out(err2)
   );

   function automatic logic [35:0] mk_head(input logic t, input logic vc,
                                           input logic [3:0] dst, input logic [27:0] p);
      return {1'b1, 1'b1, t, vc, dst, p};
   endfunction

   function automatic logic [35:0] mk_body(input logic t, input logic vc, input logic [31:0] p);
      return {1'b1, 1'b0, t, vc, p};
   endfunction

   // Reference for the two-flit instance: the head carries payload bits
   // [27:0], the body the next 32 bits; a missing body leaves zeros.
   function automatic logic [47:0] ref_n2(input logic [27:0] hp, input logic [31:0] bp,
                                          input logic has_body);
      logic [59:0] w;
      w = has_body ? {bp, hp} : {32'h0, hp};
      return w[47:0];
   endfunction

   // Present one flit (starting at a negedge) and return at the negedge
   // after the clock edge that accepted it.
   task automatic send(input int dut, input logic [35:0] f);
      int w;
      w = 0;
      if (dut == 1) begin d1_in = f; v1_in = 1'b1; end
      else          begin d2_in = f; v2_in = 1'b1; end
      while (((dut == 1) ? r1_out : r2_out) !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      v1_in = 1'b0;
      v2_in = 1'b0;
      n_cmp++;
      if (w >= 20) begin
         $display("FAIL send_timeout dut%0d: ready_out stayed %b, required 1", dut,
                  (dut == 1) ? r1_out : r2_out);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      d1_in = '0; v1_in = 1'b0; ri1 = 1'b0;
      d2_in = '0; v2_in = 1'b0; ri2 = 1'b0;
      #2;
      n_cmp++;
      if ({r1_out, vo1, err1, d1_out, t1_out, dst1, vc1} !== {1'b1, 27'h0}) begin
         $display("FAIL reset_in_dut1: got %h required %h",
                  {r1_out, vo1, err1, d1_out, t1_out, dst1, vc1}, {1'b1, 27'h0});
         n_fail++;
      end
      n_cmp++;
      if ({r2_out, vo2, err2, d2_out, t2_out, dst2, vc2} !== {1'b1, 55'h0}) begin
         $display("FAIL reset_in_dut2: got %h required %h",
                  {r2_out, vo2, err2, d2_out, t2_out, dst2, vc2}, {1'b1, 55'h0});
         n_fail++;
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({r1_out, vo1, err1, r2_out, vo2, err2} !== 6'b100100) begin
         $display("FAIL reset_after: got %b required 100100",
                  {r1_out, vo1, err1, r2_out, vo2, err2});
         n_fail++;
      end
   endtask

   task automatic test_single_flit();
      ri1 = 1'b1;
      send(1, mk_head(1'b1, 1'b0, 4'hA, 28'h0056789));
      n_cmp++;
      if ({vo1, d1_out, t1_out, dst1, vc1, err1} !== {1'b1, 12'h789, 8'h56, 4'hA, 1'b0, 1'b0}) begin
         $display("FAIL single_flit: got %h required %h", {vo1, d1_out, t1_out, dst1, vc1, err1},
                  {1'b1, 12'h789, 8'h56, 4'hA, 1'b0, 1'b0});
         n_fail++;
      end
      @(negedge clk);
      n_cmp++;
      if ({vo1, r1_out} !== 2'b01) begin
         $display("FAIL single_release: valid/ready %b required 01", {vo1, r1_out});
         n_fail++;
      end
   endtask

   task automatic test_hold_stall();
      ri1 = 1'b0;
      send(1, mk_head(1'b1, 1'b0, 4'hA, 28'h0056789));
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({vo1, r1_out, d1_out, t1_out, dst1} !== {2'b10, 12'h789, 8'h56, 4'hA}) begin
            $display("FAIL hold_stall cycle %0d: got %h required %h", i,
                     {vo1, r1_out, d1_out, t1_out, dst1}, {2'b10, 12'h789, 8'h56, 4'hA});
            n_fail++;
         end
         @(negedge clk);
      end
      ri1 = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({vo1, r1_out} !== 2'b01) begin
         $display("FAIL hold_release: valid/ready %b required 01", {vo1, r1_out});
         n_fail++;
      end
   endtask

   task automatic test_random_n1();
      logic [11:0] data;
      logic [7:0]  tag;
      logic [3:0]  dst;
      logic        vc, t;
      logic [7:0]  fill;
      int          stall;
      for (int i = 0; i < 16; i++) begin
         data  = 12'($urandom_range(0, 4095));
         tag   = 8'($urandom_range(0, 255));
         dst   = 4'($urandom_range(0, 15));
         vc    = 1'($urandom_range(0, 1));
         t     = 1'($urandom_range(0, 1));
         fill  = 8'($urandom_range(0, 255));
         stall = $urandom_range(0, 3);
         ri1   = (stall == 0);
         send(1, mk_head(t, vc, dst, {fill, tag, data}));
         n_cmp++;
         if ({vo1, d1_out, t1_out, dst1, vc1, err1} !== {1'b1, data, tag, dst, vc, 1'b0}) begin
            $display("FAIL random_n1 #%0d: got %h required %h", i,
                     {vo1, d1_out, t1_out, dst1, vc1, err1}, {1'b1, data, tag, dst, vc, 1'b0});
            n_fail++;
         end
         repeat (stall) @(negedge clk);
         n_cmp++;
         if ({vo1, d1_out, t1_out} !== {1'b1, data, tag}) begin
            $display("FAIL random_n1_stable #%0d: got %h required %h", i,
                     {vo1, d1_out, t1_out}, {1'b1, data, tag});
            n_fail++;
         end
         ri1 = 1'b1;
         @(negedge clk);
         n_cmp++;
         if ({vo1, r1_out} !== 2'b01) begin
            $display("FAIL random_n1_release #%0d: valid/ready %b required 01", i, {vo1, r1_out});
            n_fail++;
         end
      end
   endtask

   task automatic test_two_flit();
      logic [47:0] exp;
      ri2 = 1'b1;
      exp = ref_n2(28'h89ABCDE, 32'h00000C34, 1'b1);
      send(2, mk_head(1'b0, 1'b0, 4'h5, 28'h89ABCDE));
      n_cmp++;
      if ({vo2, err2} !== 2'b00) begin
         $display("FAIL two_flit_mid: valid/err %b required 00", {vo2, err2});
         n_fail++;
      end
      send(2, mk_body(1'b1, 1'b0, 32'h00000C34));
      n_cmp++;
      if ({vo2, d2_out, t2_out, dst2, vc2, err2} !== {1'b1, exp[39:0], exp[47:40], 4'h5, 1'b0, 1'b0}) begin
         $display("FAIL two_flit: got %h required %h", {vo2, d2_out, t2_out, dst2, vc2, err2},
                  {1'b1, exp[39:0], exp[47:40], 4'h5, 1'b0, 1'b0});
         n_fail++;
      end
   endtask

   task automatic test_head_restart();
      logic [27:0] hp;
      logic [31:0] bp;
      logic [47:0] exp;
      hp  = 28'($urandom);
      bp  = $urandom;
      exp = ref_n2(hp, bp, 1'b1);
      send(2, mk_head(1'b0, 1'b0, 4'h1, 28'($urandom)));
      send(2, mk_head(1'b0, 1'b1, 4'h2, hp));
      n_cmp++;
      if ({vo2, err2} !== 2'b01) begin
         $display("FAIL restart_err: valid/err %b required 01", {vo2, err2});
         n_fail++;
      end
      send(2, mk_body(1'b1, 1'b0, bp));
      n_cmp++;
      if ({vo2, d2_out, t2_out, dst2, vc2, err2} !== {1'b1, exp[39:0], exp[47:40], 4'h2, 1'b1, 1'b0}) begin
         $display("FAIL restart_packet: got %h required %h", {vo2, d2_out, t2_out, dst2, vc2, err2},
                  {1'b1, exp[39:0], exp[47:40], 4'h2, 1'b1, 1'b0});
         n_fail++;
      end
   endtask

   task automatic test_stray_null();
      logic [27:0] hp;
      logic [31:0] bp;
      logic [47:0] exp;
      send(2, mk_body(1'b1, 1'b0, $urandom));
      n_cmp++;
      if ({vo2, err2} !== 2'b01) begin
         $display("FAIL stray_body: valid/err %b required 01", {vo2, err2});
         n_fail++;
      end
      @(negedge clk);
      n_cmp++;
      if (err2 !== 1'b0) begin
         $display("FAIL stray_pulse_width: err %b required 0", err2);
         n_fail++;
      end
      send(2, {1'b0, 35'($urandom)});
      n_cmp++;
      if ({vo2, err2, r2_out} !== 3'b001) begin
         $display("FAIL null_idle: valid/err/ready %b required 001", {vo2, err2, r2_out});
         n_fail++;
      end
      send(1, {1'b0, 35'($urandom)});
      n_cmp++;
      if ({vo1, err1, r1_out} !== 3'b001) begin
         $display("FAIL null_idle_n1: valid/err/ready %b required 001", {vo1, err1, r1_out});
         n_fail++;
      end
      hp  = 28'($urandom);
      bp  = $urandom;
      exp = ref_n2(hp, bp, 1'b1);
      send(2, mk_head(1'b0, 1'b1, 4'h9, hp));
      send(2, {1'b0, 1'b1, 34'($urandom)});
      send(2, {1'b0, 1'b0, 34'($urandom)});
      n_cmp++;
      if ({vo2, err2} !== 2'b00) begin
         $display("FAIL null_body: valid/err %b required 00", {vo2, err2});
         n_fail++;
      end
      send(2, mk_body(1'b1, 1'b0, bp));
      n_cmp++;
      if ({vo2, d2_out, t2_out, dst2, vc2, err2} !== {1'b1, exp[39:0], exp[47:40], 4'h9, 1'b1, 1'b0}) begin
         $display("FAIL null_then_body: got %h required %h", {vo2, d2_out, t2_out, dst2, vc2, err2},
                  {1'b1, exp[39:0], exp[47:40], 4'h9, 1'b1, 1'b0});
         n_fail++;
      end
   endtask

   task automatic test_tail_errors();
      logic [27:0] hp;
      logic [31:0] bp;
      logic [47:0] exp;
      hp  = 28'($urandom);
      exp = ref_n2(hp, 32'h0, 1'b0);
      send(2, mk_head(1'b1, 1'b0, 4'h3, hp));
      n_cmp++;
      if ({vo2, d2_out, t2_out, dst2, err2} !== {1'b1, exp[39:0], exp[47:40], 4'h3, 1'b0}) begin
         $display("FAIL head_tail: got %h required %h", {vo2, d2_out, t2_out, dst2, err2},
                  {1'b1, exp[39:0], exp[47:40], 4'h3, 1'b0});
         n_fail++;
      end
      hp  = 28'($urandom);
      bp  = $urandom;
      exp = ref_n2(hp, bp, 1'b1);
      send(2, mk_head(1'b0, 1'b0, 4'h6, hp));
      send(2, mk_body(1'b0, 1'b0, bp));
      n_cmp++;
      if ({vo2, d2_out, t2_out, dst2, err2} !== {1'b1, exp[39:0], exp[47:40], 4'h6, 1'b1}) begin
         $display("FAIL missing_tail: got %h required %h", {vo2, d2_out, t2_out, dst2, err2},
                  {1'b1, exp[39:0], exp[47:40], 4'h6, 1'b1});
         n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      logic [27:0] hp;
      logic [31:0] bp;
      logic [47:0] exp;
      ri1 = 1'b0;
      send(1, mk_head(1'b1, 1'b1, 4'h7, 28'h1234567));
      n_cmp++;
      if (vo1 !== 1'b1) begin
         $display("FAIL reset_setup_hold: valid %b required 1", vo1);
         n_fail++;
      end
      send(2, mk_head(1'b0, 1'b0, 4'hC, 28'($urandom)));
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({vo1, r1_out, d1_out, vo2, r2_out, err2, d2_out, dst2} !== {2'b01, 12'h0, 3'b010, 40'h0, 4'h0}) begin
         $display("FAIL reset_mid: got %h required %h",
                  {vo1, r1_out, d1_out, vo2, r2_out, err2, d2_out, dst2},
                  {2'b01, 12'h0, 3'b010, 40'h0, 4'h0});
         n_fail++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      ri1   = 1'b1;
      send(2, mk_body(1'b1, 1'b0, $urandom));
      n_cmp++;
      if ({vo2, err2} !== 2'b01) begin
         $display("FAIL reset_stray_body: valid/err %b required 01", {vo2, err2});
         n_fail++;
      end
      hp  = 28'($urandom);
      bp  = $urandom;
      exp = ref_n2(hp, bp, 1'b1);
      send(2, mk_head(1'b0, 1'b0, 4'hD, hp));
      send(2, mk_body(1'b1, 1'b1, bp));
      n_cmp++;
      if ({vo2, d2_out, t2_out, dst2, err2} !== {1'b1, exp[39:0], exp[47:40], 4'hD, 1'b0}) begin
         $display("FAIL reset_recover: got %h required %h", {vo2, d2_out, t2_out, dst2, err2},
                  {1'b1, exp[39:0], exp[47:40], 4'hD, 1'b0});
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      logic [39:0] data;
      logic [7:0]  tag;
      logic [3:0]  dst;
      logic        vc;
      logic [11:0] fill;
      logic [47:0] pay;
      int          last_cyc;
      ri2 = 1'b1;
      @(negedge clk);
      last_cyc = 0;
      for (int i = 0; i < 12; i++) begin
         r    = {$urandom, $urandom};
         data = r[39:0];
         tag  = 8'($urandom_range(0, 255));
         dst  = 4'($urandom_range(0, 15));
         vc   = 1'($urandom_range(0, 1));
         fill = 12'($urandom_range(0, 4095));
         pay  = {tag, data};
         send(2, mk_head(1'b0, vc, dst, pay[27:0]));
         send(2, mk_body(1'b1, ~vc, {fill, pay[47:28]}));
         n_cmp++;
         if ({vo2, d2_out, t2_out, dst2, vc2, err2} !== {1'b1, data, tag, dst, vc, 1'b0}) begin
            $display("FAIL b2b_packet #%0d: got %h required %h", i,
                     {vo2, d2_out, t2_out, dst2, vc2, err2}, {1'b1, data, tag, dst, vc, 1'b0});
            n_fail++;
         end
         if (i > 0) begin
            n_cmp++;
            if (cyc - last_cyc !== 3) begin
               $display("FAIL b2b_period #%0d: %0d cycles per packet, required 3", i,
                        cyc - last_cyc);
               n_fail++;
            end
         end
         last_cyc = cyc;
      end
   endtask

   initial begin
      test_reset();
      test_single_flit();
      test_hold_stall();
      test_random_n1();
      test_two_flit();
      test_head_restart();
      test_stray_null();
      test_tail_errors();
      test_reset_mid();
      test_back_to_back();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
